// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - commit-stage bus between the writeback stage and cp0_unit
interface cp0_unit_if;
  logic        commit_valid;
  logic        commit_exc;
  logic [4:0]  commit_excode;
  logic        commit_bd;
  logic [31:0] commit_pc;
  logic [31:0] commit_badvaddr;
  logic        commit_eret;
  logic        commit_mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic        int_pending;

  modport master (
    output commit_valid, commit_exc, commit_excode, commit_bd, commit_pc,
           commit_badvaddr, commit_eret, commit_mtc0, cp0_addr, mtc0_data,
    input  cp0_rdata, flush, flush_pc, int_pending
  );

  modport slave (
    input  commit_valid, commit_exc, commit_excode, commit_bd, commit_pc,
           commit_badvaddr, commit_eret, commit_mtc0, cp0_addr, mtc0_data,
    output cp0_rdata, flush, flush_pc, int_pending
  );
endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS CP0 (BadVAddr/Count/Compare/Status/Cause/EPC) with interrupt/exception arbitration
// Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_unit #(
  parameter int          HW_INT_N    = 6,
  parameter int          SYNC_STAGES = 2,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter logic [31:0] STATUS_RST  = 32'h00400000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HW_INT_N-1:0] hw_int,
  cp0_unit_if.slave           bus
);
  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  logic [SYNC_STAGES-1:0][HW_INT_N-1:0] sync_q;
  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [31:0] status_q, epc_q, badvaddr_q, cause_val;
  logic        cause_bd_q;
  logic [4:0]  excode_q;
  logic [1:0]  ip_sw_q;
  logic        exl, take_int, take_exc, eret_go, flush_raw, mtc0_go;
  logic [31:0] count_q, compare_q;
  logic        ti_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], hw_int};
  end

  always_comb begin
    hw_ip = '0;
    hw_ip[HW_INT_N-1:0] = sync_q[SYNC_STAGES-1];
  end

  // IP[7] is shared between hardware line 5 and the timer
  assign ip        = {hw_ip[5] | ti_q, hw_ip[4:0], ip_sw_q};
  assign cause_val = {cause_bd_q, ti_q, 14'd0, ip, 1'b0, excode_q, 2'b00};
  assign exl       = status_q[1];

  assign bus.int_pending = status_q[0] & ~exl & (|(ip & status_q[15:8]));
  assign take_int  = bus.commit_valid & bus.int_pending;
  assign take_exc  = bus.commit_valid & bus.commit_exc & ~take_int;
  assign eret_go   = bus.commit_valid & bus.commit_eret & ~take_int & ~take_exc;
  assign flush_raw = take_int | take_exc | eret_go;
  assign mtc0_go   = bus.commit_valid & bus.commit_mtc0 & ~flush_raw;
  assign bus.flush    = rst_n & flush_raw;
  assign bus.flush_pc = eret_go ? epc_q : EXC_VECTOR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      cause_bd_q <= 1'b0;
      excode_q   <= '0;
      ip_sw_q    <= '0;
    end else if (take_int || take_exc) begin
      excode_q    <= take_int ? 5'd0 : bus.commit_excode;
      status_q[1] <= 1'b1;
      // nested exceptions keep the outer return address
      if (!exl) begin
        epc_q      <= bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc;
        cause_bd_q <= bus.commit_bd;
      end
      if (take_exc && (bus.commit_excode == 5'd4 || bus.commit_excode == 5'd5))
        badvaddr_q <= bus.commit_badvaddr;
    end else if (eret_go) begin
      status_q[1] <= 1'b0;
    end else if (mtc0_go) begin
      case (bus.cp0_addr)
        A_STATUS: status_q <= {status_q[31:16], bus.mtc0_data[15:8], status_q[7:2], bus.mtc0_data[1:0]};
        A_CAUSE:  ip_sw_q  <= bus.mtc0_data[9:8];
        A_EPC:    epc_q    <= bus.mtc0_data;
        default:  ;
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] phase_q;
  logic [31:0]   count_d;
  logic          tick, count_wr, compare_wr;

  assign tick       = (phase_q == PW'(COUNT_DIV - 1));
  assign count_wr   = mtc0_go && (bus.cp0_addr == A_COUNT);
  assign compare_wr = mtc0_go && (bus.cp0_addr == A_COMPARE);
  assign count_d    = count_wr ? bus.mtc0_data : (tick ? count_q + 32'd1 : count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      phase_q <= (count_wr || tick) ? '0 : phase_q + PW'(1);
      count_q <= count_d;
      if (compare_wr) compare_q <= bus.mtc0_data;
      // clearing via Compare wins over a same-cycle match
      if (compare_wr)
        ti_q <= 1'b0;
      else if (count_d != count_q && count_d == compare_q)
        ti_q <= 1'b1;
    end
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign ti_q      = 1'b0;
`endif

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      A_BADVADDR: bus.cp0_rdata = badvaddr_q;
      A_COUNT:    bus.cp0_rdata = count_q;
      A_COMPARE:  bus.cp0_rdata = compare_q;
      A_STATUS:   bus.cp0_rdata = status_q;
      A_CAUSE:    bus.cp0_rdata = cause_val;
      A_EPC:      bus.cp0_rdata = epc_q;
      default:    bus.cp0_rdata = '0;
    endcase
  end
endmodule
